// File: rtl/spi_flash_read_seq.sv
`timescale 1ns/1ps
// spi_flash_read_seq: drives a byte-level SPI engine through a flash READ (opcode, 24-bit address,
// len data bytes) and streams the received bytes out over a valid/ready interface.
module spi_flash_read_seq #(
   parameter logic [7:0] CMD_READ = 8'h03,
   parameter int         CS_GAP   = 2,
   parameter int         LEN_W    = 8
) (
   input  logic             core_clk,
   input  logic             core_rstn,
   input  logic             start,
   input  logic [23:0]      addr,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             spi_csb,
   output logic             xfer_go,
   output logic [7:0]       xfer_tx,
   input  logic             xfer_done,
   input  logic [7:0]       xfer_rx,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   input  logic             rd_ready
);
   typedef enum logic [3:0] {IDLE, CS_SETUP, CMD, ADR2, ADR1, ADR0, DATA, OUT, CS_HOLD} state_t;
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
   state_t           state;
   logic [7:0]       cnt;
   logic [LEN_W-1:0] rem;
   logic [23:0]      addr_q;
   logic             ab_q;
   logic             ab;
   // a one-cycle abort is remembered until the outstanding byte exchange completes
   assign ab = abort | ab_q;
   always_ff @(posedge core_clk or negedge core_rstn) begin
      if (!core_rstn) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         addr_q   <= '0;
         ab_q     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         spi_csb  <= 1'b1;
         xfer_go  <= 1'b0;
         xfer_tx  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         done    <= 1'b0;
         xfer_go <= 1'b0;
         if (state != IDLE && abort) ab_q <= 1'b1;
         case (state)
            IDLE: if (start && !abort) begin
               aborted <= 1'b0;
               if (len == '0) done <= 1'b1;
               else begin
                  addr_q  <= addr;
                  rem     <= len;
                  ab_q    <= 1'b0;
                  busy    <= 1'b1;
                  spi_csb <= 1'b0;
                  cnt     <= '0;
                  state   <= CS_SETUP;
               end
            end
            CS_SETUP:
               if (ab) begin
                  aborted <= 1'b1;
                  cnt     <= '0;
                  state   <= CS_HOLD;
               end else if (cnt == GAP_LAST) begin
                  xfer_go <= 1'b1;
                  xfer_tx <= CMD_READ;
                  state   <= CMD;
               end else cnt <= cnt + 8'd1;
            CMD, ADR2, ADR1, ADR0: if (xfer_done) begin
               if (ab) begin
                  aborted <= 1'b1;
                  cnt     <= '0;
                  state   <= CS_HOLD;
               end else begin
                  xfer_go <= 1'b1;
                  xfer_tx <= state == CMD ? addr_q[23:16] : state == ADR2 ? addr_q[15:8] : state == ADR1 ? addr_q[7:0] : 8'h00;
                  state   <= state == CMD ? ADR2 : state == ADR2 ? ADR1 : state == ADR1 ? ADR0 : DATA;
               end
            end
            DATA: if (xfer_done) begin
               if (ab) begin
                  aborted <= 1'b1;
                  cnt     <= '0;
                  state   <= CS_HOLD;
               end else begin
                  rd_data  <= xfer_rx;
                  rd_valid <= 1'b1;
                  rem      <= rem - LEN_W'(1);
                  state    <= OUT;
               end
            end
            OUT:
               if (ab) begin
                  rd_valid <= 1'b0;
                  aborted  <= 1'b1;
                  cnt      <= '0;
                  state    <= CS_HOLD;
               end else if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (rem != '0) begin
                     xfer_go <= 1'b1;
                     xfer_tx <= 8'h00;
                     state   <= DATA;
                  end else begin
                     cnt   <= '0;
                     state <= CS_HOLD;
                  end
               end
            CS_HOLD: begin
               if (abort) aborted <= 1'b1;
               if (cnt == GAP_LAST) begin
                  spi_csb <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= IDLE;
               end else cnt <= cnt + 8'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_flash_read_seq.sv
`timescale 1ns/1ps
// tb_spi_flash_read_seq: SPI engine + flash model, reference READ model and protocol monitors
// around spi_flash_read_seq.
module tb_spi_flash_read_seq;
   localparam int CS_GAP = 2;
   localparam logic [7:0] CMD = 8'h03;
   localparam int MSZ = 512;
   localparam int LIMIT = 5000;

   logic core_clk = 1'b0, core_rstn = 1'b0;
   logic start = 1'b0, abort = 1'b0, rd_ready = 1'b0, xfer_done = 1'b0;
   logic [23:0] addr = '0;
   logic [7:0] len = '0, xfer_rx = '0;
   logic busy, done, aborted, spi_csb, xfer_go, rd_valid;
   logic [7:0] xfer_tx, rd_data;

   logic [7:0] mem [MSZ];
   logic [7:0] tx_q[$], rd_q[$];
   int go_cnt = 0, eng_k = 1, eng_cnt = 0, fidx = 0;
   logic [23:0] faddr = '0;
   logic [7:0] resp = '0, pd = '0;
   int v_rv = 0, v_ov = 0, v_cs = 0, v_st = 0, v_dn = 0;
   bit outst = 0, pv = 0, pdone = 0;
   int total = 0, passed = 0, fails = 0;

   spi_flash_read_seq #(.CMD_READ(CMD), .CS_GAP(CS_GAP), .LEN_W(8)) dut (
      .core_clk(core_clk), .core_rstn(core_rstn), .start(start), .addr(addr), .len(len),
      .abort(abort), .busy(busy), .done(done), .aborted(aborted), .spi_csb(spi_csb),
      .xfer_go(xfer_go), .xfer_tx(xfer_tx), .xfer_done(xfer_done), .xfer_rx(xfer_rx),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
   );

   always #5 core_clk = ~core_clk;

   // engine answers eng_k cycles after xfer_go; flash parses opcode+address, then streams mem
   always @(posedge core_clk) begin
      #1;
      xfer_done = 1'b0;
      if (spi_csb) fidx = 0;
      if (!core_rstn) eng_cnt = 0;
      else begin
         if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               xfer_done = 1'b1;
               xfer_rx = resp;
            end
         end
         if (xfer_go) begin
            if (fidx >= 1 && fidx <= 3) faddr = {faddr[15:0], xfer_tx};
            resp = fidx < 4 ? 8'($urandom) : mem[(int'(faddr) + fidx - 4) % MSZ];
            fidx++;
            eng_cnt = eng_k;
         end
      end
   end

   always @(negedge core_clk) begin
      if (spi_csb !== !busy) v_cs++;
      if (xfer_go && spi_csb) v_cs++;
      if (!core_rstn) begin
         outst = 0;
         pv = 0;
         pdone = 0;
      end else begin
         if (xfer_done) outst = 0;
         if (xfer_go) begin
            go_cnt++;
            tx_q.push_back(xfer_tx);
            if (outst) v_ov++;
            if (rd_valid) v_rv++;
            outst = 1;
         end
         if (rd_valid && rd_ready) rd_q.push_back(rd_data);
         if (pv && rd_valid && rd_data !== pd) v_st++;
         pv = rd_valid && !rd_ready;
         pd = rd_data;
         if (done && pdone) v_dn++;
         pdone = done;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at posedge+1; returns at posedge+1 of the cycle after done
   task automatic run(input string tag, input logic [23:0] a, input int n, input int kk,
                      input int mode, input int ab_byte, input bit busy_start);
      int cyc, first_v, last_evt, exp_tx_n, exp_rd_n;
      bit got_done, got_ab, ab_fired, exp_ab;
      logic csb1;
      logic [7:0] e;
      cyc = 0; first_v = 0; last_evt = 0;
      got_done = 0; got_ab = 0; ab_fired = 0; csb1 = 1'bx;
      exp_ab = ab_byte != 0 && n != 0;
      eng_k = kk;
      go_cnt = 0;
      tx_q.delete();
      rd_q.delete();
      start = 1'b1;
      addr = a;
      len = 8'(n);
      rd_ready = mode == 0;
      while (!got_done && cyc < LIMIT) begin
         @(posedge core_clk); #1;
         start = busy_start && cyc == 6;
         if (start) begin
            addr = ~a;
            len = 8'd9;
         end
         rd_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 3) : 1'($urandom_range(0, 1));
         abort = exp_ab && !ab_fired && go_cnt == ab_byte;
         if (abort) ab_fired = 1;
         @(negedge core_clk);
         cyc++;
         if (cyc == 1) csb1 = spi_csb;
         if (rd_valid && first_v == 0) first_v = cyc;
         if (xfer_done || (rd_valid && rd_ready)) last_evt = cyc;
         if (done) begin
            got_done = 1;
            got_ab = aborted;
         end
      end
      @(posedge core_clk); #1;
      abort = 1'b0;
      chk({tag, "_done_seen"}, got_done, 1);
      chk({tag, "_cs_fall"}, csb1, n == 0);
      if (n == 0) chk({tag, "_done_lat"}, cyc, 1);
      else chk({tag, "_done_gap"}, cyc - last_evt, CS_GAP + 1);
      chk({tag, "_aborted"}, got_ab, exp_ab);
      exp_tx_n = n == 0 ? 0 : exp_ab ? ab_byte : 4 + n;
      chk({tag, "_tx_n"}, tx_q.size(), exp_tx_n);
      for (int j = 0; j < exp_tx_n && j < tx_q.size(); j++) begin
         e = j == 0 ? CMD : j < 4 ? 8'(a >> (8 * (3 - j))) : 8'h00;
         chk($sformatf("%s_tx%0d", tag, j), tx_q[j], e);
      end
      exp_rd_n = (n == 0 || exp_ab) ? 0 : n;
      chk({tag, "_rd_n"}, rd_q.size(), exp_rd_n);
      for (int i = 0; i < exp_rd_n && i < rd_q.size(); i++)
         chk($sformatf("%s_rd%0d", tag, i), rd_q[i], mem[(int'(a) + i) % MSZ]);
      if (mode == 0 && !exp_ab && n != 0)
         chk({tag, "_first_valid"}, first_v, 1 + CS_GAP + 4 * (kk + 1) + kk + 1);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_csb_end"}, spi_csb, 1);
      chk({tag, "_go_while_valid"}, v_rv, 0);
      chk({tag, "_go_overlap"}, v_ov, 0);
      chk({tag, "_csb_vs_busy"}, v_cs, 0);
      chk({tag, "_stall_stable"}, v_st, 0);
      chk({tag, "_done_width"}, v_dn, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_csb"}, spi_csb, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_aborted"}, aborted, 0);
      chk({tag, "_go"}, xfer_go, 0);
      chk({tag, "_tx"}, xfer_tx, 0);
      chk({tag, "_valid"}, rd_valid, 0);
      chk({tag, "_data"}, rd_data, 0);
   endtask

   initial begin
      logic [7:0] pre [11];
      pre = '{8'h93, 8'h01, 8'h00, 8'h13, 8'h02, 8'h63, 8'h57, 8'hb5, 8'h00, 8'h23, 8'h20};
      for (int i = 0; i < MSZ; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 11; i++) mem[i] = pre[i];
      repeat (2) @(posedge core_clk);
      #1;
      chk_reset("rst");
      core_rstn = 1'b1;
      run("pre11", 24'h000000, 11, 2, 0, 0, 0);
      run("stall", 24'h000004, 3, 3, 1, 0, 0);
      start = 1'b1;
      abort = 1'b1;
      addr = 24'h0;
      len = 8'd5;
      @(posedge core_clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge core_clk);
      chk("start_abort_busy", busy, 0);
      chk("start_abort_csb", spi_csb, 1);
      chk("start_abort_done", done, 0);
      @(posedge core_clk); #1;
      run("len0", 24'h000100, 0, 2, 0, 0, 0);
      run("abort_adr1", 24'h000010, 5, 4, 0, 3, 0);
      run("abort_data", 24'h000020, 4, 3, 0, 5, 0);
      run("busy_start", 24'h000030, 6, 1, 2, 0, 1);
      run("b2b", 24'h000040, 7, 2, 0, 0, 0);
      go_cnt = 0;
      eng_k = 2;
      rd_ready = 1'b1;
      start = 1'b1;
      addr = 24'h0;
      len = 8'd11;
      @(posedge core_clk); #1;
      start = 1'b0;
      for (int c = 0; c < 200 && go_cnt < 7; c++) begin
         @(posedge core_clk); #1;
      end
      chk("rst_reach_data", go_cnt >= 7, 1);
      #2 core_rstn = 1'b0;
      #1;
      chk_reset("rst_async");
      repeat (2) @(posedge core_clk);
      #1;
      core_rstn = 1'b1;
      run("after_rst", 24'h000000, 11, 2, 0, 0, 0);
      for (int t = 0; t < 8; t++)
         run($sformatf("rnd%0d", t), 24'($urandom), $urandom_range(1, 40), $urandom_range(1, 4),
             $urandom_range(0, 2), 0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
